pe_inv: RTL and testbench

//  Inverse (decimation-in-time) radix-2 butterfly processing element; the receive-side counterpart of the forward PE.

---
 rtl/pe_pkg.sv | 13 +
 rtl/pe_tw_mult.sv | 37 +++
 rtl/pe_inv.sv | 120 ++++++++++++
 tb/tb_pe_inv.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared defaults and types for the radix-2 butterfly processing elements
//   DEF_WIDTH  : default sample/twiddle width (two's complement)
//   DEF_SHIFT  : default twiddle fractional bits
//   PE_INV_LAT : accept-to-out_valid latency of pe_inv with no stall
//   sample_t   : one sample at the default width
//   product_t  : full-precision product of two samples
package pe_pkg;
   localparam int DEF_WIDTH  = 32;
   localparam int DEF_SHIFT  = 16;
   localparam int PE_INV_LAT = 3;
   typedef logic signed [DEF_WIDTH-1:0]   sample_t;
   typedef logic signed [2*DEF_WIDTH-1:0] product_t;
endpackage

// File: rtl/pe_tw_mult.sv
// pe_tw_mult: registered signed twiddle multiply with fixed-point slice and bypass mux
//   Clk, Reset_n : clock, synchronous active-low reset
//   en           : pipeline advance enable
//   byp_n        : 0 passes a through unscaled, 1 selects the scaled product
//   a, tf        : sample and twiddle (WIDTH, two's complement)
//   p            : registered result, (a*tf) >> SHIFT truncated to WIDTH
// Build option: PE_INV_ROUND_EN adds half an LSB before slicing (round half up);
// without it the slice truncates toward minus infinity.
module pe_tw_mult
   import pe_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SHIFT = DEF_SHIFT
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             en,
   input  logic             byp_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] tf,
   output logic [WIDTH-1:0] p
);
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_r;
   // Sign-extending both operands to full width makes the low 2*WIDTH bits of
   // an unsigned multiply equal to the signed product.
   assign prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{tf[WIDTH-1]}}, tf};
`ifdef PE_INV_ROUND_EN
   assign prod_r = prod + ((2*WIDTH)'(1) << (SHIFT-1));
`else
   assign prod_r = prod;
`endif
   always_ff @(posedge Clk) begin
      if (!Reset_n) p <= '0;
      else if (en)  p <= byp_n ? WIDTH'(prod_r >> SHIFT) : a;
   end
endmodule

// File: rtl/pe_inv.sv
// pe_inv: inverse (decimation-in-time) radix-2 butterfly processing element
//   Clk, Reset_n        : clock, synchronous active-low reset
//   in_valid/in_ready   : input beat handshake, in_sof marks the first beat of a frame
//   in0..in3            : sum0, sum1, twiddled diff0, twiddled diff1
//   tw_addr / tf        : twiddle ROM index for the current input beat / its inverse twiddle
//   bypass_n            : 0 skips the multiply, in2/in3 go to add/sub unscaled
//   out_valid/out_ready : output beat handshake, out_sof follows its beat
//   out0..out3          : in0+p0, in0-p0, in1+p1, in1-p1 (modulo 2^WIDTH)
// Build option: PE_INV_ROUND_EN selects round-half-up in the twiddle multiply.
// Three register stages share one enable, so a stall freezes the whole pipe.
module pe_inv
   import pe_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int SHIFT  = DEF_SHIFT,
   parameter int TW_LEN = 16,
   parameter int TW_AW  = 4
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sof,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   output logic [TW_AW-1:0] tw_addr,
   input  logic [WIDTH-1:0] tf,
   input  logic             bypass_n,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sof,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3
);
   logic             en;
   logic             acc;
   logic [TW_AW-1:0] cnt;
   logic [TW_AW-1:0] idx;
   logic             s1_v, s1_sof, s1_byp_n;
   logic [WIDTH-1:0] s1_in0, s1_in1, s1_in2, s1_in3, s1_tf;
   logic             s2_v, s2_sof;
   logic [WIDTH-1:0] s2_in0, s2_in1, p0, p1;

   assign en       = ~out_valid | out_ready;
   assign in_ready = en;
   assign acc      = in_valid & en;
   // A start-of-frame beat restarts the twiddle sequence even on the wrap beat.
   assign idx      = in_sof ? '0 : cnt;
   assign tw_addr  = idx;

   always_ff @(posedge Clk) begin
      if (!Reset_n) cnt <= '0;
      else if (acc) cnt <= (idx == TW_AW'(TW_LEN-1)) ? '0 : idx + TW_AW'(1);
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         s1_v     <= 1'b0;
         s1_sof   <= 1'b0;
         s1_byp_n <= 1'b0;
         s1_in0   <= '0;
         s1_in1   <= '0;
         s1_in2   <= '0;
         s1_in3   <= '0;
         s1_tf    <= '0;
      end else if (en) begin
         s1_v     <= in_valid & in_ready;
         s1_sof   <= in_sof;
         s1_byp_n <= bypass_n;
         s1_in0   <= in0;
         s1_in1   <= in1;
         s1_in2   <= in2;
         s1_in3   <= in3;
         s1_tf    <= tf;
      end
   end

   pe_tw_mult #(.WIDTH(WIDTH), .SHIFT(SHIFT)) u_mult0 (
      .Clk(Clk), .Reset_n(Reset_n), .en(en), .byp_n(s1_byp_n), .a(s1_in2), .tf(s1_tf), .p(p0)
   );
   pe_tw_mult #(.WIDTH(WIDTH), .SHIFT(SHIFT)) u_mult1 (
      .Clk(Clk), .Reset_n(Reset_n), .en(en), .byp_n(s1_byp_n), .a(s1_in3), .tf(s1_tf), .p(p1)
   );

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         s2_v   <= 1'b0;
         s2_sof <= 1'b0;
         s2_in0 <= '0;
         s2_in1 <= '0;
      end else if (en) begin
         s2_v   <= s1_v;
         s2_sof <= s1_sof;
         s2_in0 <= s1_in0;
         s2_in1 <= s1_in1;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out0      <= '0;
         out1      <= '0;
         out2      <= '0;
         out3      <= '0;
      end else if (en) begin
         out_valid <= s2_v;
         out_sof   <= s2_sof;
         out0      <= s2_in0 + p0;
         out1      <= s2_in0 - p0;
         out2      <= s2_in1 + p1;
         out3      <= s2_in1 - p1;
      end
   end
endmodule

// File: tb/tb_pe_inv.sv
// tb_pe_inv: self-checking bench for pe_inv (table vectors + scoreboard queue)
module tb_pe_inv;
   import pe_pkg::*;
   localparam int W   = 32;
   localparam int TWL = 4;
   localparam int TWA = 4;

   logic           Clk = 1'b0;
   logic           Reset_n = 1'b0;
   logic           in_valid = 1'b0, in_sof = 1'b0, bypass_n = 1'b1, out_ready = 1'b1;
   logic [W-1:0]   in0 = '0, in1 = '0, in2 = '0, in3 = '0, tf = '0;
   logic           in_ready, out_valid, out_sof;
   logic [TWA-1:0] tw_addr;
   logic [W-1:0]   out0, out1, out2, out3;

   pe_inv #(.WIDTH(W), .SHIFT(16), .TW_LEN(TWL), .TW_AW(TWA)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3), .tw_addr(tw_addr), .tf(tf), .bypass_n(bypass_n),
      .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
      .out0(out0), .out1(out1), .out2(out2), .out3(out3)
   );

   always #5 Clk = ~Clk;

   typedef struct { logic [W-1:0] o0, o1, o2, o3; logic sof; } exp_t;
   typedef struct { logic [W-1:0] i0, i1, i2, i3, t; logic byp; logic [W-1:0] e0, e1, e2, e3; } vec_t;

   exp_t           q[$];
   exp_t           exp_cur;
   vec_t           vt[6];
   int             checks = 0, failures = 0;
   int             m_cnt = 0;
   logic           acc_f;
   logic [TWA-1:0] last_tw;

   function automatic logic [W-1:0] pm(logic [W-1:0] a, logic [W-1:0] t, logic byp);
      longint pr;
      if (!byp) return a;
      pr = longint'($signed(a)) * longint'($signed(t));
`ifdef PE_INV_ROUND_EN
      pr = pr + 64'sd32768;
`endif
      return W'(pr >>> 16);
   endfunction

   task automatic chk(string n, logic [W-1:0] a, logic [W-1:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", n, a, e);
      end
   endtask

   task automatic drive(logic [W-1:0] a0, logic [W-1:0] a1, logic [W-1:0] a2, logic [W-1:0] a3,
                        logic [W-1:0] t, logic b, logic s);
      logic [W-1:0] p0, p1;
      in_valid = 1'b1; in_sof = s; bypass_n = b;
      in0 = a0; in1 = a1; in2 = a2; in3 = a3; tf = t;
      p0 = pm(a2, t, b);
      p1 = pm(a3, t, b);
      exp_cur = '{a0 + p0, a0 - p0, a1 + p1, a1 - p1, s};
   endtask

   task automatic tick();
      int ix;
      exp_t e;
      #1;
      ix = in_sof ? 0 : m_cnt;
      chk("tw_addr", W'(tw_addr), W'(ix));
      acc_f = in_valid && in_ready;
      if (acc_f) begin
         last_tw = tw_addr;
         q.push_back(exp_cur);
         m_cnt = (ix == TWL-1) ? 0 : ix + 1;
      end
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_beat actual=valid required=none out0=%0h", out0);
         end else begin
            e = q.pop_front();
            chk("out0", out0, e.o0);
            chk("out1", out1, e.o1);
            chk("out2", out2, e.o2);
            chk("out3", out3, e.o3);
            chk("out_sof", W'(out_sof), W'(e.sof));
         end
      end
      @(negedge Clk);
   endtask

   task automatic drain();
      int n = 0;
      in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
      while (q.size() > 0 && n < 20) begin
         tick();
         n++;
      end
      chk("drain_left", W'(q.size()), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W-1:0] snap0, snap3;
      int b;
      int seq[10] = '{0, 1, 2, 3, 0, 1, 0, 1, 2, 3};
      vt[0] = '{100, 50, 20, -10, 32'h00010000, 1'b1, 120, 80, 40, 60};
`ifdef PE_INV_ROUND_EN
      vt[1] = '{0, 0, 3, 0, 32'h00008000, 1'b1, 2, -2, 0, 0};
      vt[3] = '{10, 0, -3, 0, 32'h00008000, 1'b1, 9, 11, 0, 0};
`else
      vt[1] = '{0, 0, 3, 0, 32'h00008000, 1'b1, 1, -1, 0, 0};
      vt[3] = '{10, 0, -3, 0, 32'h00008000, 1'b1, 8, 12, 0, 0};
`endif
      vt[2] = '{7, 0, 5, 0, 32'h7FFFFFFF, 1'b0, 12, 2, 0, 0};
      vt[4] = '{32'h7FFFFFFF, 32'h80000000, 1, 1, 32'h00010000, 1'b1,
                32'h80000000, 32'h7FFFFFFE, 32'h80000001, 32'h7FFFFFFF};
      vt[5] = '{0, 1, 7, -4, 32'hFFFF0000, 1'b1, -7, 7, 5, -3};

      // reset state
      @(negedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      #1;
      chk("rst_out_valid", W'(out_valid), 0);
      chk("rst_in_ready", W'(in_ready), 1);
      chk("rst_tw_addr", W'(tw_addr), 0);
      chk("rst_out0", out0, 0);
      chk("rst_out_sof", W'(out_sof), 0);
      @(negedge Clk);

      // single beat: latency and one-cycle valid pulse
      drive(vt[0].i0, vt[0].i1, vt[0].i2, vt[0].i3, vt[0].t, vt[0].byp, 1'b1);
      tick();
      in_valid = 1'b0; in_sof = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         chk("latency_valid", W'(out_valid), W'(k == PE_INV_LAT));
         tick();
      end

      // table vectors back to back
      for (int i = 0; i < 6; i++) begin
         drive(vt[i].i0, vt[i].i1, vt[i].i2, vt[i].i3, vt[i].t, vt[i].byp, i == 0);
         exp_cur.o0 = vt[i].e0; exp_cur.o1 = vt[i].e1;
         exp_cur.o2 = vt[i].e2; exp_cur.o3 = vt[i].e3;
         tick();
      end
      drain();

      // 6-beat burst with out_ready low for 4 cycles
      b = 0;
      snap0 = '0; snap3 = '0;
      for (int c = 0; c < 40 && (b < 6 || q.size() > 0); c++) begin
         out_ready = !(c >= 4 && c < 8);
         if (b < 6) drive(b * 1000, -b, b * 7 + 1, 3 - b, b[0] ? 32'hFFFF4000 : 32'h00018000, b != 4, b == 0);
         else begin in_valid = 1'b0; in_sof = 1'b0; end
         if (c >= 4 && c < 8) begin
            #1;
            chk("stall_in_ready", W'(in_ready), 0);
            chk("stall_out_valid", W'(out_valid), 1);
            if (c == 4) begin snap0 = out0; snap3 = out3; end
            else begin chk("stall_hold0", out0, snap0); chk("stall_hold3", out3, snap3); end
         end
         tick();
         if (acc_f) b++;
      end
      chk("burst_beats", W'(b), 6);
      drain();

      // twiddle index sequence with sof on beats 0 and 6, bubble after beat 2
      for (int i = 0; i < 10; i++) begin
         drive(i, i + 1, i * 3, -i, 32'h00010000, 1'b1, i == 0 || i == 6);
         tick();
         chk("tw_seq", W'(last_tw), W'(seq[i]));
         if (i == 2) begin
            in_valid = 1'b0; in_sof = 1'b0;
            tick();
         end
      end
      // sof on the wrap beat wins
      for (int i = 0; i < 5; i++) begin
         drive(i, 0, 2, 0, 32'h00020000, 1'b1, i == 3);
         tick();
         chk("tw_wrap_sof", W'(last_tw), W'(i == 3 ? 0 : (i == 4 ? 1 : i)));
      end
      drain();

      // reset with two beats in flight
      drive(11, 22, 33, 44, 32'h00010000, 1'b1, 1'b1);
      tick();
      drive(55, 66, 77, 88, 32'h00010000, 1'b1, 1'b0);
      tick();
      in_valid = 1'b0; in_sof = 1'b0; Reset_n = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      q.delete();
      m_cnt = 0;
      #1;
      chk("mid_rst_out_valid", W'(out_valid), 0);
      chk("mid_rst_out0", out0, 0);
      chk("mid_rst_out3", out3, 0);
      chk("mid_rst_tw_addr", W'(tw_addr), 0);
      chk("mid_rst_in_ready", W'(in_ready), 1);
      drive(5, 6, 7, 8, 32'h00010000, 1'b1, 1'b0);
      tick();
      chk("post_rst_tw", W'(last_tw), 0);
      drain();
      for (int k = 0; k < 4; k++) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
